// File: rtl/cayde_ex_stage.sv
// cayde RV32 execute stage: ID/EX register, operand forwarding, load-use stall, EX/MEM register.
// Optional perf counters enabled by defining CAYDE_EX_PERF_EN.
package cayde_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op;

    typedef struct packed {
        alu_op       op;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        use_pc;
        logic        use_imm;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [31:0] pc;
    } ex_mem_t;
endpackage

module cayde_ex_stage
    import cayde_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  cayde_pkg::alu_op      id_alu_op_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_rd_we_i,
    input  logic                  id_is_load_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic                  id_use_pc_i,
    input  logic                  id_use_imm_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic                  flush_i,
    output cayde_pkg::alu_op      alu_op_o,
    output logic [XLEN-1:0]       alu_a_o,
    output logic [XLEN-1:0]       alu_b_o,
    input  logic [XLEN-1:0]       alu_res_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [XLEN-1:0]       ex_res_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  ex_rd_we_o,
    output logic                  ex_is_load_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
);

    logic    v1_q, v1_d, v2_q, v2_d;
    id_ex_t  s1_q, s1_d;
    ex_mem_t s2_q, s2_d;
    logic    s2_free, hazard, fire1, accept;
    logic [XLEN-1:0] fwd1, fwd2;

    function automatic logic [31:0] fwd(
        input logic [4:0]  rs,
        input logic [31:0] rf,
        input logic        v2,
        input ex_mem_t     s2,
        input logic        wbwe,
        input logic [4:0]  wbrd,
        input logic [31:0] wbd
    );
        logic [31:0] r;
        r = rf;
        if (rs != 5'd0) begin
            // A load in EX/MEM only has its address, never forward it
            if (v2 && s2.we && !s2.ld && s2.rd == rs)
                r = s2.res;
            else if (wbwe && wbrd == rs)
                r = wbd;
        end
        return r;
    endfunction

    always_comb begin
        s2_free = !v2_q || ex_ready_i;
        hazard  = v1_q && v2_q && s2_q.ld && (s2_q.rd != 5'd0) &&
                  ((s2_q.rd == s1_q.rs1a && !s1_q.use_pc) ||
                   (s2_q.rd == s1_q.rs2a && !s1_q.use_imm));
        fire1      = v1_q && !hazard && s2_free;
        id_ready_o = !rst_i && !flush_i && (!v1_q || fire1);
        accept     = id_valid_i && id_ready_o;

        fwd1 = fwd(s1_q.rs1a, s1_q.rs1d, v2_q, s2_q,
                   wb_we_i, wb_rd_i, wb_data_i);
        fwd2 = fwd(s1_q.rs2a, s1_q.rs2d, v2_q, s2_q,
                   wb_we_i, wb_rd_i, wb_data_i);
        alu_a_o  = s1_q.use_pc  ? s1_q.pc  : fwd1;
        alu_b_o  = s1_q.use_imm ? s1_q.imm : fwd2;
        alu_op_o = v1_q ? s1_q.op : ALU_ADD;

        v1_d = v1_q;
        s1_d = s1_q;
        if (accept) begin
            v1_d = 1'b1;
            s1_d = '{op: id_alu_op_i, rs1d: id_rs1_data_i,
                     rs2d: id_rs2_data_i, rs1a: id_rs1_addr_i,
                     rs2a: id_rs2_addr_i, rd: id_rd_addr_i,
                     we: id_rd_we_i, ld: id_is_load_i,
                     imm: id_imm_i, pc: id_pc_i,
                     use_pc: id_use_pc_i, use_imm: id_use_imm_i};
        end else if (fire1) begin
            v1_d = 1'b0;
        end

        v2_d = v2_q;
        s2_d = s2_q;
        if (fire1) begin
            v2_d = 1'b1;
            s2_d = '{res: alu_res_i, rd: s1_q.rd, we: s1_q.we,
                     ld: s1_q.ld, pc: s1_q.pc};
        end else if (ex_ready_i) begin
            v2_d = 1'b0;
        end

        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign ex_valid_o   = v2_q;
    assign ex_res_o     = s2_q.res;
    assign ex_rd_o      = s2_q.rd;
    assign ex_rd_we_o   = s2_q.we;
    assign ex_is_load_o = s2_q.ld;
    assign ex_pc_o      = s2_q.pc;

`ifdef CAYDE_EX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, hazard};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cayde_ex_stage.sv
// Testbench for cayde_ex_stage: ALU vector table plus forwarding, stall, backpressure,
// flush and reset sequences, checked through an output scoreboard.
module tb_cayde_ex_stage;
    import cayde_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i, id_ready_o;
    alu_op       id_alu_op_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_rd_we_i, id_is_load_i;
    logic [31:0] id_imm_i, id_pc_i;
    logic        id_use_pc_i, id_use_imm_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    alu_op       alu_op_o;
    logic [31:0] alu_a_o, alu_b_o, alu_res_i;
    logic        ex_valid_o, ex_ready_i;
    logic [31:0] ex_res_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rd_we_o, ex_is_load_o;
    logic [31:0] ex_pc_o, perf_stall_cnt_o, perf_flush_cnt_o;

    always #5 clk_i = ~clk_i;

    cayde_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_alu_op_i(id_alu_op_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i),
        .id_is_load_i(id_is_load_i), .id_imm_i(id_imm_i),
        .id_pc_i(id_pc_i), .id_use_pc_i(id_use_pc_i),
        .id_use_imm_i(id_use_imm_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_res_i(alu_res_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_res_o(ex_res_o), .ex_rd_o(ex_rd_o),
        .ex_rd_we_o(ex_rd_we_o), .ex_is_load_o(ex_is_load_o),
        .ex_pc_o(ex_pc_o),
        .perf_stall_cnt_o(perf_stall_cnt_o),
        .perf_flush_cnt_o(perf_flush_cnt_o)
    );

    // Combinational ALU environment
    always_comb begin
        alu_res_i = alu_a_o + alu_b_o;
        case (alu_op_o)
            ALU_SUB:  alu_res_i = alu_a_o - alu_b_o;
            ALU_AND:  alu_res_i = alu_a_o & alu_b_o;
            ALU_OR:   alu_res_i = alu_a_o | alu_b_o;
            ALU_XOR:  alu_res_i = alu_a_o ^ alu_b_o;
            ALU_SLL:  alu_res_i = alu_a_o << alu_b_o[4:0];
            ALU_SRL:  alu_res_i = alu_a_o >> alu_b_o[4:0];
            ALU_SRA:  alu_res_i = $signed(alu_a_o) >>> alu_b_o[4:0];
            ALU_SLT:  alu_res_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
            ALU_SLTU: alu_res_i = {31'd0, alu_a_o < alu_b_o};
            default:  alu_res_i = alu_a_o + alu_b_o;
        endcase
    end

    typedef struct {
        alu_op       op;
        logic [4:0]  rs1a, rs2a, rd;
        logic [31:0] rs1d, rs2d, imm, pc;
        logic        use_pc, use_imm, we, ld;
    } in_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        in_t         i;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pop = -1;
    int          prev_pop = -1;
    logic [31:0] held;
    logic [31:0] exp_flush;
    vec_t        vt[10];

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic in_t mk(alu_op op, logic [4:0] rs1a, logic [31:0] rs1d,
                               logic [4:0] rs2a, logic [31:0] rs2d,
                               logic [31:0] imm, logic [31:0] pc,
                               logic use_pc, logic use_imm,
                               logic [4:0] rd, logic we, logic ld);
        in_t r;
        r.op = op; r.rs1a = rs1a; r.rs1d = rs1d; r.rs2a = rs2a;
        r.rs2d = rs2d; r.imm = imm; r.pc = pc; r.use_pc = use_pc;
        r.use_imm = use_imm; r.rd = rd; r.we = we; r.ld = ld;
        return r;
    endfunction

    function automatic exp_t mke(logic [31:0] res, logic [4:0] rd, logic [31:0] pc);
        exp_t e;
        e.res = res; e.rd = rd; e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        id_alu_op_i = i.op; id_rs1_addr_i = i.rs1a; id_rs1_data_i = i.rs1d;
        id_rs2_addr_i = i.rs2a; id_rs2_data_i = i.rs2d; id_imm_i = i.imm;
        id_pc_i = i.pc; id_use_pc_i = i.use_pc; id_use_imm_i = i.use_imm;
        id_rd_addr_i = i.rd; id_rd_we_i = i.we; id_is_load_i = i.ld;
    endtask

    task automatic issue(input in_t i, input exp_t e);
        bit done;
        done = 1'b0;
        @(negedge clk_i);
        drive(i);
        id_valid_i = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            #4;
            if (id_ready_o) begin
                sb.push_back(e);
                done = 1'b1;
                @(posedge clk_i);
                #1;
            end else begin
                @(negedge clk_i);
            end
        end
        id_valid_i = 1'b0;
        chk("issue_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk_i);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    // Output monitor: one sample just before each rising edge
    always begin
        @(negedge clk_i);
        #4;
        if (!rst_i && ex_valid_o && ex_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got output %h expected none", ex_res_o);
            end else begin
                mon_e = sb.pop_front();
                chk("ex_res", ex_res_o, mon_e.res);
                chk("ex_rd", {27'd0, ex_rd_o}, {27'd0, mon_e.rd});
                chk("ex_pc", ex_pc_o, mon_e.pc);
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; id_valid_i = 1'b0; ex_ready_i = 1'b1; flush_i = 1'b0;
        wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        drive(mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef CAYDE_EX_PERF_EN
        exp_flush = 32'd1;
`else
        exp_flush = 32'd0;
`endif

        vt[0] = '{mk(ALU_ADD, 6, 3, 7, 4, 0, 32'h200, 0, 0, 8, 0, 0), 32'd7};
        vt[1] = '{mk(ALU_SUB, 6, 10, 7, 3, 0, 32'h204, 0, 0, 9, 0, 0), 32'd7};
        vt[2] = '{mk(ALU_AND, 6, 32'hF0F0F0F0, 7, 32'hFF00FF00, 0, 32'h208, 0, 0, 10, 0, 0), 32'hF000F000};
        vt[3] = '{mk(ALU_OR, 6, 32'h0F0F0000, 7, 32'h000000F0, 0, 32'h20C, 0, 0, 11, 0, 0), 32'h0F0F00F0};
        vt[4] = '{mk(ALU_XOR, 6, 32'hAAAA5555, 7, 32'hFFFF0000, 0, 32'h210, 0, 0, 12, 0, 0), 32'h55555555};
        vt[5] = '{mk(ALU_ADD, 6, 32'h9999, 7, 32'h8888, 4, 32'h1000, 1, 1, 13, 0, 0), 32'h1004};
        vt[6] = '{mk(ALU_SLT, 6, 32'hFFFFFFFF, 7, 1, 0, 32'h218, 0, 0, 14, 0, 0), 32'd1};
        vt[7] = '{mk(ALU_SLTU, 6, 32'hFFFFFFFF, 7, 1, 0, 32'h21C, 0, 0, 15, 0, 0), 32'd0};
        vt[8] = '{mk(ALU_SLL, 6, 1, 7, 32'h55, 4, 32'h220, 0, 1, 16, 0, 0), 32'h10};
        vt[9] = '{mk(ALU_SRA, 6, 32'h80000000, 7, 0, 4, 32'h224, 0, 1, 17, 0, 0), 32'hF8000000};

        // Reset state
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_ex_res", ex_res_o, 32'd0);
        chk("rst_alu_a", alu_a_o, 32'd0);
        chk("rst_alu_b", alu_b_o, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op_o}, {28'd0, ALU_ADD});
        chk("rst_id_ready", {31'd0, id_ready_o}, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // ALU vector table, full throughput
        for (int k = 0; k < 10; k++)
            issue(vt[k].i, mke(vt[k].exp, vt[k].i.rd, vt[k].i.pc));
        drain();

        // ADDI x1=x0+5 ; ADD x2=x1+x1, EX/MEM forward beats a stale WB value
        wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h999;
        issue(mk(ALU_ADD, 0, 0, 0, 0, 5, 32'h300, 0, 1, 1, 1, 0), mke(5, 1, 32'h300));
        issue(mk(ALU_ADD, 1, 32'hBAD, 1, 32'hBAD, 0, 32'h304, 0, 0, 2, 1, 0), mke(10, 2, 32'h304));
        drain();
        wb_we_i = 1'b0;
        chk("b2b_gap", last_pop - prev_pop, 32'd1);

        // LW x3 ; ADD x4=x3+x0 -> one bubble, then WB forward
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h100, 32'h400, 0, 1, 3, 1, 1), mke(32'h100, 3, 32'h400));
        issue(mk(ALU_ADD, 3, 32'h0, 0, 0, 0, 32'h404, 0, 0, 4, 1, 0), mke(32'h77, 4, 32'h404));
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h77;
        @(negedge clk_i); #1;
        chk("lu_stall_ready", {31'd0, id_ready_o}, 32'd0);
        @(negedge clk_i); #1;
        chk("lu_bubble", {31'd0, ex_valid_o}, 32'd0);
        @(negedge clk_i); #1;
        chk("lu_add_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("lu_add_res", ex_res_o, 32'h77);
`ifdef CAYDE_EX_PERF_EN
        chk("lu_perf_stall", perf_stall_cnt_o, 32'd1);
`else
        chk("lu_perf_stall", perf_stall_cnt_o, 32'd0);
`endif
        drain();
        wb_we_i = 1'b0;

        // Backpressure for 3 cycles with 3 instructions
        ex_ready_i = 1'b0;
        fork
            begin
                issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h11, 32'h500, 0, 1, 20, 0, 0), mke(32'h11, 20, 32'h500));
                issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h22, 32'h504, 0, 1, 21, 0, 0), mke(32'h22, 21, 32'h504));
                issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h33, 32'h508, 0, 1, 22, 0, 0), mke(32'h33, 22, 32'h508));
            end
            begin : hold_chk
                int k;
                k = 0;
                do begin
                    @(negedge clk_i); #1;
                    k++;
                end while (!ex_valid_o && k < 20);
                chk("hold_valid", {31'd0, ex_valid_o}, 32'd1);
                held = ex_res_o;
                repeat (3) begin
                    @(negedge clk_i); #1;
                    chk("hold_res", ex_res_o, held);
                    chk("hold_ready", {31'd0, id_ready_o}, 32'd0);
                end
                ex_ready_i = 1'b1;
            end
        join
        drain();

        // Flush with both slots full and a new instruction offered
        ex_ready_i = 1'b0;
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h44, 32'h600, 0, 1, 23, 0, 0), mke(32'h44, 23, 32'h600));
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h55, 32'h604, 0, 1, 24, 0, 0), mke(32'h55, 24, 32'h604));
        @(negedge clk_i);
        drive(mk(ALU_ADD, 0, 0, 0, 0, 32'h66, 32'h608, 0, 1, 25, 0, 0));
        id_valid_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_id_ready", {31'd0, id_ready_o}, 32'd0);
        chk("flush_pre_valid", {31'd0, ex_valid_o}, 32'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        id_valid_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
        chk("flush_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("flush_perf", perf_flush_cnt_o, exp_flush);
        ex_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("flush_no_ghost", {31'd0, ex_valid_o}, 32'd0);

        // Write x0 then read x0: never forwarded, even from WB
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEADBEEF;
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h55, 32'h700, 0, 1, 0, 1, 0), mke(32'h55, 0, 32'h700));
        issue(mk(ALU_ADD, 0, 0, 0, 0, 0, 32'h704, 0, 0, 5, 1, 0), mke(32'h0, 5, 32'h704));
        drain();
        wb_we_i = 1'b0;

        // Asynchronous reset mid-stream
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h81, 32'h800, 0, 1, 26, 0, 0), mke(32'h81, 26, 32'h800));
        issue(mk(ALU_ADD, 0, 0, 0, 0, 32'h82, 32'h804, 0, 1, 27, 0, 0), mke(32'h82, 27, 32'h804));
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("arst_ex_res", ex_res_o, 32'd0);
        chk("arst_ex_pc", ex_pc_o, 32'd0);
        chk("arst_alu_a", alu_a_o, 32'd0);
        chk("arst_alu_b", alu_b_o, 32'd0);
        chk("arst_alu_op", {28'd0, alu_op_o}, {28'd0, ALU_ADD});
        chk("arst_id_ready", {31'd0, id_ready_o}, 32'd0);
        chk("arst_perf_flush", perf_flush_cnt_o, 32'd0);
        sb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        issue(mk(ALU_SUB, 6, 32'h100, 7, 32'h1, 0, 32'h900, 0, 0, 28, 1, 0), mke(32'hFF, 28, 32'h900));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
